vec_alu_seq: RTL and testbench
==============================

VEC_ALU_SEQ -- requirements
Module: vec_alu_seq

Interface
REQ-001 SHALL have parameter N, default 8: width of one vector element in bits.
REQ-002 SHALL have parameter V, default 16: number of elements in one vector.
REQ-003 SHALL have parameter L, default 4: number of lanes in the shared ALU slice; V SHALL be an integer multiple of L.
REQ-004 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1: synchronous, active-high reset.
REQ-006 Port in_valid, input, 1: a vector operation is offered.
REQ-007 Port in_ready, output, 1: the block can accept an operation.
REQ-008 Port in_a, input, V*N: operand vector A; element i is bits [i*N +: N].
REQ-009 Port in_b, input, V*N: operand vector B, packed the same way.
REQ-010 Port in_op, input, 3: operation code.
REQ-011 Port alu_a, output, L*N: lane operands A driven to the external shared ALU slice.
REQ-012 Port alu_b, output, L*N: lane operands B driven to the slice.
REQ-013 Port alu_op, output, 3: operation code driven to the slice.
REQ-014 Port alu_res, input, L*N: combinational slice result for the current alu_a, alu_b and alu_op.
REQ-015 Port out_valid, output, 1: out_res holds a completed result.
REQ-016 Port out_ready, input, 1: the consumer accepts out_res.
REQ-017 Port out_res, output, V*N: result vector.
REQ-018 Port busy, output, 1: high when the state is not IDLE.

Function
REQ-019 The block SHALL use exactly three states: IDLE, ISSUE and DONE.
REQ-020 in_ready SHALL equal (state == IDLE).
REQ-021 Accept: in IDLE with in_valid = 1, the block SHALL latch in_a, in_b and in_op and clear the pass counter to 0.
- If the latched op is 3'b111, the next state SHALL be DONE.
- Otherwise, the next state SHALL be ISSUE.
REQ-022 Each ISSUE cycle with pass counter p, the block SHALL drive:
- alu_a = latched A elements p*L .. p*L+L-1;
- alu_b = latched B elements p*L .. p*L+L-1;
- alu_op = latched op.
At the next clock edge it SHALL write alu_res into the same elements of the result buffer.
REQ-023 The pass counter SHALL be ceil(log2(V/L)) bits wide.
- In ISSUE it SHALL increment by 1 each cycle.
- When p = V/L-1, the next state SHALL be DONE and the counter SHALL wrap to 0.
REQ-024 Op 3'b111 (pass-through) SHALL NOT use the slice; the result buffer SHALL be loaded with the latched A on the accept edge.
REQ-025 Outside ISSUE, alu_a, alu_b and alu_op SHALL be driven to 0.
REQ-026 In DONE, out_valid SHALL be 1 and out_res SHALL be driven from the result buffer, held stable until the handshake completes.
REQ-027 Leaving DONE:
- out_ready = 1 in DONE SHALL move the state to IDLE.
- out_ready = 0 SHALL keep the state in DONE.
- No new operation SHALL be accepted in the same cycle as the output handshake.
REQ-028 Latency: for a non-pass-through op accepted at edge t, out_valid SHALL first be high in the cycle after edge t+V/L; for op 3'b111 it SHALL be high in the cycle after edge t.
REQ-029 In IDLE, the in_a, in_b and in_op inputs SHALL be ignored when in_valid = 0; in ISSUE and DONE they SHALL be ignored regardless of in_valid.
REQ-030 Element arithmetic SHALL come entirely from alu_res, with no width change; overflow handling belongs to the slice.
REQ-031 The result buffer SHALL be written only in ISSUE or on a pass-through accept.

Reset
REQ-032 rst = 1 at a clock edge SHALL force state IDLE, pass counter 0, latched operands 0, latched op 0 and result buffer 0.
- Consequently in_ready = 1, out_valid = 0, busy = 0, alu_* = 0 and out_res = 0.
REQ-033 A reset during ISSUE or DONE SHALL abandon the operation; no out_valid pulse for it SHALL appear afterwards.

Verification
REQ-034 Add: in_op = 3'b000 (slice add), A[i] = i, B[i] = 2*i, V=16, L=4, out_ready held at 1 -> exactly 4 ISSUE cycles with alu_a lanes {0,1,2,3}, {4..7}, {8..11}, {12..15} in order; out_valid at the 5th cycle after accept; out_res[i] = 3*i.
REQ-035 Pass-through: in_op = 3'b111, A[i] = 8'hA0+i -> alu_* stays 0; out_valid in the cycle after accept; out_res = A.
REQ-036 Backpressure: out_ready held at 0 for 6 cycles in DONE, with in_valid = 1 and changing in_a -> out_res stable, in_ready = 0, and no new operation accepted; on the cycle out_ready = 1, the state returns to IDLE.
REQ-037 Back-to-back: two operations offered continuously -> the second is accepted in the first IDLE cycle after the first completes; both results are correct and in order.
REQ-038 Reset mid-op: rst asserted at the 2nd ISSUE cycle -> the next cycle shows in_ready = 1, out_valid = 0, out_res = 0; a fresh operation then completes normally.

Source files
------------

// File: rtl/vec_alu_seq_if.sv
// Signal bundle for vec_alu_seq: operation input handshake, the lane bus to the
// external shared ALU slice, the result output handshake and status/debug.
interface vec_alu_seq_if #(
  parameter int N = 8,
  parameter int V = 16,
  parameter int L = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [V*N-1:0]   in_a;
  logic [V*N-1:0]   in_b;
  logic [2:0]       in_op;
  logic [L*N-1:0]   alu_a;
  logic [L*N-1:0]   alu_b;
  logic [2:0]       alu_op;
  logic [L*N-1:0]   alu_res;
  logic             out_valid;
  logic             out_ready;
  logic [V*N-1:0]   out_res;
  logic             busy;
  logic [1:0]       dbg_state;

  // Block side.
  modport slave (
    input  in_valid, in_a, in_b, in_op, alu_res, out_ready,
    output in_ready, alu_a, alu_b, alu_op, out_valid, out_res, busy, dbg_state
  );

  // Environment side: producer, ALU slice and consumer.
  modport master (
    output in_valid, in_a, in_b, in_op, alu_res, out_ready,
    input  in_ready, alu_a, alu_b, alu_op, out_valid, out_res, busy, dbg_state
  );
endinterface

// File: rtl/vec_alu_seq.sv
// Sequential vector ALU: processes a V-element vector through an external
// L-lane combinational ALU slice, L elements per cycle, V/L cycles per op.
// Op 3'b111 is a pass-through that bypasses the slice entirely.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are both
// high. The producer holds its payload while valid is high and ready is low;
// ready never depends combinationally on valid. Here in_ready is high only in
// IDLE and out_valid only in DONE, so an output handshake and a new accept can
// never happen on the same edge.
module vec_alu_seq #(
  parameter int N = 8,
  parameter int V = 16,
  parameter int L = 4
) (
  input  logic         clk,
  input  logic         rst,
  vec_alu_seq_if.slave bus
);
  localparam int P  = V / L;
  localparam int PW = (P > 1) ? $clog2(P) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(P - 1);
  localparam logic [2:0] OP_PASS = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [PW-1:0]   pass_q;
  logic [V*N-1:0]  a_q;
  logic [V*N-1:0]  b_q;
  logic [V*N-1:0]  res_q;
  logic [2:0]      op_q;
  int              lane_lo;

  // Bit offset of the lane group handled in the current pass.
  assign lane_lo = int'(pass_q) * L * N;

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.in_valid) state_d = (bus.in_op == OP_PASS) ? DONE : ISSUE;
      ISSUE:   if (pass_q == P_LAST) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Slice operands: the current lane group while issuing, zero otherwise.
  always_comb begin
    bus.alu_a  = '0;
    bus.alu_b  = '0;
    bus.alu_op = '0;
    if (state_q == ISSUE) begin
      bus.alu_a  = a_q[lane_lo +: L*N];
      bus.alu_b  = b_q[lane_lo +: L*N];
      bus.alu_op = op_q;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Operand latch, pass counter and result buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      pass_q <= '0;
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      res_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_q    <= bus.in_a;
            b_q    <= bus.in_b;
            op_q   <= bus.in_op;
            pass_q <= '0;
            if (bus.in_op == OP_PASS) res_q <= bus.in_a;
          end
        end
        ISSUE: begin
          res_q[lane_lo +: L*N] <= bus.alu_res;
          pass_q <= (pass_q == P_LAST) ? '0 : pass_q + PW'(1);
        end
        default: ;
      endcase
    end
  end

  // Status and result outputs.
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_res   = res_q;
  assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_vec_alu_seq.sv
// Directed bench for vec_alu_seq with a behavioural ALU slice and a result
// scoreboard: expected vectors are queued at accept and compared at handshake.
module tb_vec_alu_seq;
  localparam int N  = 8;
  localparam int V  = 16;
  localparam int L  = 4;
  localparam int P  = V / L;
  localparam int VN = V * N;
  localparam int LN = L * N;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [VN-1:0] exp_q[$];

  vec_alu_seq_if #(.N(N), .V(V), .L(L)) bus ();

  vec_alu_seq #(.N(N), .V(V), .L(L)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [N-1:0] elem_op(input logic [N-1:0] a, input logic [N-1:0] b,
                                           input logic [2:0] op);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return a;
      3'd6:    return b;
      default: return a;
    endcase
  endfunction

  function automatic logic [LN-1:0] slice(input logic [LN-1:0] a, input logic [LN-1:0] b,
                                          input logic [2:0] op);
    logic [LN-1:0] r;
    r = '0;
    for (int j = 0; j < L; j++) r[j*N +: N] = elem_op(a[j*N +: N], b[j*N +: N], op);
    return r;
  endfunction

  function automatic logic [VN-1:0] model(input logic [VN-1:0] a, input logic [VN-1:0] b,
                                          input logic [2:0] op);
    logic [VN-1:0] r;
    r = '0;
    for (int i = 0; i < V; i++) r[i*N +: N] = elem_op(a[i*N +: N], b[i*N +: N], op);
    return r;
  endfunction

  function automatic logic [VN-1:0] rand_vec();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // External ALU slice.
  assign bus.alu_res = slice(bus.alu_a, bus.alu_b, bus.alu_op);

  task automatic check(input string tag, input logic [VN-1:0] got, input logic [VN-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      tick();
      n++;
    end
    checks++;
    assert (bus.in_ready === 1'b1) else begin
      errors++;
      $error("FAIL %s: in_ready=%b after %0d cycles, expected 1", tag, bus.in_ready, n);
    end
  endtask

  // Scoreboard: compare each completed result at its output handshake.
  always @(negedge clk) begin
    if (!rst && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      checks++;
      assert (exp_q.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_out: out_res=%h with empty expected queue, expected none", bus.out_res);
      end
      if (exp_q.size() > 0) check("out_res", bus.out_res, exp_q.pop_front());
    end
  end

  initial begin
    logic [VN-1:0] a;
    logic [VN-1:0] b;
    logic [VN-1:0] exp_bp;
    logic [LN-1:0] la;
    logic [LN-1:0] lb;
    int n;
    bit seen;

    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.in_op = '0;
    bus.out_ready = 1'b0;

    // Reset state.
    tick();
    tick();
    check("rst_in_ready", VN'(bus.in_ready), VN'(1));
    check("rst_out_valid", VN'(bus.out_valid), VN'(0));
    check("rst_busy", VN'(bus.busy), VN'(0));
    check("rst_alu_a", VN'(bus.alu_a), VN'(0));
    check("rst_alu_op", VN'(bus.alu_op), VN'(0));
    check("rst_out_res", bus.out_res, VN'(0));
    check("rst_state", VN'(bus.dbg_state), VN'(0));
    rst = 1'b0;
    bus.in_a = rand_vec();
    tick();
    check("idle_ignore", VN'(bus.dbg_state), VN'(0));

    // Add: A[i]=i, B[i]=2i; lane groups issued in order, result 3i.
    bus.out_ready = 1'b1;
    for (int i = 0; i < V; i++) begin
      a[i*N +: N] = N'(i);
      b[i*N +: N] = N'(2 * i);
    end
    bus.in_a = a;
    bus.in_b = b;
    bus.in_op = 3'b000;
    bus.in_valid = 1'b1;
    exp_q.push_back(model(a, b, 3'b000));
    tick();
    bus.in_valid = 1'b0;
    bus.in_a = rand_vec();
    bus.in_b = rand_vec();
    for (int k = 0; k < P; k++) begin
      for (int j = 0; j < L; j++) begin
        la[j*N +: N] = N'(k * L + j);
        lb[j*N +: N] = N'(2 * (k * L + j));
      end
      check("add_alu_a", VN'(bus.alu_a), VN'(la));
      check("add_alu_b", VN'(bus.alu_b), VN'(lb));
      check("add_alu_op", VN'(bus.alu_op), VN'(0));
      check("add_state_issue", VN'(bus.dbg_state), VN'(1));
      check("add_no_early_valid", VN'(bus.out_valid), VN'(0));
      tick();
    end
    check("add_latency", VN'(bus.out_valid), VN'(1));
    tick();
    check("add_back_idle", VN'(bus.in_ready), VN'(1));

    // Pass-through: slice untouched, result in the cycle after accept.
    for (int i = 0; i < V; i++) a[i*N +: N] = 8'hA0 + N'(i);
    bus.in_a = a;
    bus.in_b = rand_vec();
    bus.in_op = 3'b111;
    bus.in_valid = 1'b1;
    exp_q.push_back(a);
    tick();
    bus.in_valid = 1'b0;
    check("pass_out_valid", VN'(bus.out_valid), VN'(1));
    check("pass_alu_a", VN'(bus.alu_a), VN'(0));
    check("pass_alu_b", VN'(bus.alu_b), VN'(0));
    check("pass_alu_op", VN'(bus.alu_op), VN'(0));
    tick();
    check("pass_back_idle", VN'(bus.in_ready), VN'(1));

    // Backpressure: consumer stalls 6 cycles while new operations are offered.
    bus.out_ready = 1'b0;
    a = rand_vec();
    b = rand_vec();
    exp_bp = model(a, b, 3'b001);
    bus.in_a = a;
    bus.in_b = b;
    bus.in_op = 3'b001;
    bus.in_valid = 1'b1;
    exp_q.push_back(exp_bp);
    tick();
    bus.in_valid = 1'b0;
    for (int k = 0; k < P; k++) tick();
    for (int k = 0; k < 6; k++) begin
      bus.in_valid = 1'b1;
      bus.in_a = rand_vec();
      bus.in_op = 3'($urandom_range(0, 7));
      check("bp_out_valid", VN'(bus.out_valid), VN'(1));
      check("bp_in_ready", VN'(bus.in_ready), VN'(0));
      check("bp_out_res_stable", bus.out_res, exp_bp);
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    check("bp_handshake_idle", VN'(bus.dbg_state), VN'(0));
    check("bp_no_accept", VN'(bus.out_valid), VN'(0));
    bus.in_valid = 1'b0;
    tick();
    check("bp_still_idle", VN'(bus.in_ready), VN'(1));

    // Back-to-back: second op offered continuously, accepted in first IDLE cycle.
    a = rand_vec();
    b = rand_vec();
    bus.in_a = a;
    bus.in_b = b;
    bus.in_op = 3'b100;
    bus.in_valid = 1'b1;
    exp_q.push_back(model(a, b, 3'b100));
    tick();
    a = rand_vec();
    b = rand_vec();
    bus.in_a = a;
    bus.in_b = b;
    bus.in_op = 3'b010;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      tick();
      n++;
    end
    check("b2b_accept_gap", VN'(n), VN'(P + 1));
    exp_q.push_back(model(a, b, 3'b010));
    tick();
    bus.in_valid = 1'b0;
    wait_idle("b2b_done");
    check("b2b_queue_drained", VN'(exp_q.size()), VN'(0));

    // Reset in the 2nd ISSUE cycle abandons the op.
    bus.in_a = rand_vec();
    bus.in_b = rand_vec();
    bus.in_op = 3'b000;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_in_ready", VN'(bus.in_ready), VN'(1));
    check("mid_rst_out_valid", VN'(bus.out_valid), VN'(0));
    check("mid_rst_out_res", bus.out_res, VN'(0));
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (bus.out_valid === 1'b1) seen = 1'b1;
      tick();
    end
    check("mid_rst_no_pulse", VN'(seen), VN'(0));

    // Fresh operation after the reset completes normally.
    a = rand_vec();
    b = rand_vec();
    bus.in_a = a;
    bus.in_b = b;
    bus.in_op = 3'b011;
    bus.in_valid = 1'b1;
    exp_q.push_back(model(a, b, 3'b011));
    tick();
    bus.in_valid = 1'b0;
    wait_idle("post_rst_done");
    tick();
    check("final_queue_empty", VN'(exp_q.size()), VN'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
